// File: rtl/proc_sequencer_if.sv
// Instruction ROM / processor-side bus of proc_sequencer: ROM address and read
// data, plus the DIN / Run / Done issue handshake with the processor core.
interface proc_sequencer_if #(
  parameter int AW = 5
);
  logic [AW-1:0] addr;
  logic [15:0]   mem_q;
  logic [15:0]   din;
  logic          run;
  logic          done;

  modport master (output addr, din, run, input mem_q, done);
  modport slave  (input addr, din, run, output mem_q, done);
endinterface

// File: rtl/proc_sequencer.sv
// Program sequencer: walks a PC over the instruction ROM, issues each word to the
// multicycle processor and waits for Done. Optional SEQ_SINGLE_STEP_EN adds step control.
module proc_sequencer #(
  parameter int AW         = 5,
  parameter int START_ADDR = 0,
  parameter int LAST_ADDR  = 31,
  parameter int TIMEOUT    = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  proc_sequencer_if.master  bus,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [15:0]       instr_count
);

  localparam logic [AW-1:0] START_PC = AW'(START_ADDR);
  localparam logic [AW-1:0] LAST_PC  = AW'(LAST_ADDR);
  localparam int            WCW      = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
`ifdef SEQ_SINGLE_STEP_EN
    S_PAUSE,
`endif
    S_ERR
  } state_t;

  state_t         state;
  logic [AW-1:0]  pc;
  logic           stop_pending;
  logic [WCW-1:0] wait_cnt;
  logic           run_q;

  // NOTE: every register below is updated with <= so all flops see pre-edge values;
  // a blocking = here would make later statements see half-updated state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      pc           <= START_PC;
      run_q        <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      error        <= 1'b0;
      instr_count  <= 16'h0000;
      stop_pending <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      run_q <= 1'b0;
      // Stop is latched in any busy state; later assignments below (halt, start) win.
      if (busy && stop) stop_pending <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            pc           <= START_PC;
            instr_count  <= 16'h0000;
            halted       <= 1'b0;
            stop_pending <= 1'b0;
            busy         <= 1'b1;
            state        <= S_FETCH;
          end
        end

        S_FETCH: begin
          run_q <= 1'b1;
          state <= S_ISSUE;
        end

        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.done) begin
            if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
            if (pc == LAST_PC || stop_pending || stop) begin
              busy         <= 1'b0;
              halted       <= 1'b1;
              stop_pending <= 1'b0;
              state        <= S_IDLE;
            end else begin
              pc <= pc + 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
              state <= step_mode ? S_PAUSE : S_FETCH;
`else
              state <= S_FETCH;
`endif
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            // Done may still arrive on the TIMEOUT-th WAIT cycle; give up only after it.
            if (wait_cnt == WAIT_LIMIT) begin
              busy  <= 1'b0;
              error <= 1'b1;
              state <= S_ERR;
            end
          end
        end

`ifdef SEQ_SINGLE_STEP_EN
        S_PAUSE: begin
          if (stop || stop_pending) begin
            busy         <= 1'b0;
            halted       <= 1'b1;
            stop_pending <= 1'b0;
            state        <= S_IDLE;
          end else if (step || !step_mode) begin
            state <= S_FETCH;
          end
        end
`endif

        S_ERR: begin
          state <= S_ERR;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.addr = pc;
  assign bus.run  = run_q;

  // The ROM word only becomes valid during ISSUE, so DIN is gated rather than registered.
  // NOTE: the default assignment first keeps this always_comb from inferring a latch.
  always_comb begin
    bus.din = 16'h0000;
    if (state == S_ISSUE) bus.din = bus.mem_q;
  end

endmodule
